// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and common constants.
// ASCII_NEWLINE is also consumed by the receive sound controller.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 5208;

  localparam logic [7:0] ASCII_NEWLINE = 8'h0A;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit; both flops take RESET_VAL on reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic FPGA_clock,
  input  logic reset,
  input  logic async_bit,
  output logic sync_bit
);

  logic meta;

  always_ff @(posedge FPGA_clock) begin
    if (reset) begin
      meta     <= RESET_VAL;
      sync_bit <= RESET_VAL;
    end else begin
      meta     <= async_bit;
      sync_bit <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: samples each bit at its center and delivers good bytes
// with a one-cycle strobe, flagging bad stop bits and riding out line breaks.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       FPGA_clock,
  input  logic       reset,
  input  logic       serial_rx,
  output logic [7:0] text_rx,
  output logic       text_ready_rx,
  output logic       frame_error,
  output logic       rx_busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  rx_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    text_n;
  logic          ready_n, ferr_n;
  logic          rx_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .FPGA_clock (FPGA_clock),
    .reset      (reset),
    .async_bit  (serial_rx),
    .sync_bit   (rx_s)
  );

  always_ff @(posedge FPGA_clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      shreg         <= '0;
      text_rx       <= 8'h00;
      text_ready_rx <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      idx           <= idx_n;
      shreg         <= shreg_n;
      text_rx       <= text_n;
      text_ready_rx <= ready_n;
      frame_error   <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    text_n  = text_rx;
    ready_n = 1'b0;
    ferr_n  = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_s) begin
          cnt_n   = '0;
          state_n = START;
        end
      end

      // A start bit that is high again at mid-bit was only a glitch.
      START: begin
        if (cnt == HALF_M1) begin
          cnt_n = '0;
          if (!rx_s) begin
            idx_n   = 3'd0;
            state_n = DATA;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      DATA: begin
        if (cnt == LAST_CNT) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg[7:1]};
          if (idx == 3'd7) begin
            state_n = STOP;
          end else begin
            idx_n = idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      STOP: begin
        if (cnt == LAST_CNT) begin
          cnt_n = '0;
          if (rx_s) begin
            text_n  = shreg;
            ready_n = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = BREAK;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      // A held-low line must return high before another start bit counts.
      BREAK: begin
        if (rx_s) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer at 16 clocks per bit:
// table-driven frames plus hand-written glitch, break and reset sequences.
module tb_uart_rx_deserializer;
  import uart_pkg::*;

  localparam int CPB = 16;
  localparam int LATENCY = 3 + CPB / 2 + 9 * CPB;

  logic       FPGA_clock = 1'b0;
  logic       reset = 1'b1;
  logic       serial_rx = 1'b1;
  logic [7:0] text_rx;
  logic       text_ready_rx;
  logic       frame_error;
  logic       rx_busy;

  uart_rx_deserializer #(.CLKS_PER_BIT(CPB)) dut (
    .FPGA_clock    (FPGA_clock),
    .reset         (reset),
    .serial_rx     (serial_rx),
    .text_rx       (text_rx),
    .text_ready_rx (text_ready_rx),
    .frame_error   (frame_error),
    .rx_busy       (rx_busy)
  );

  always #5 FPGA_clock = ~FPGA_clock;

  int cyc = 0;
  always @(posedge FPGA_clock) cyc <= cyc + 1;

  logic [7:0] got_val [256];
  int         got_cyc [256];
  int         got_n  = 0;
  int         ferr_n = 0;
  int         both_n = 0;
  int         busy_n = 0;

  // Record every DUT strobe away from the active edge.
  always @(negedge FPGA_clock) begin
    if (text_ready_rx && got_n < 256) begin
      got_val[got_n] <= text_rx;
      got_cyc[got_n] <= cyc;
      got_n          <= got_n + 1;
    end
    if (frame_error) ferr_n <= ferr_n + 1;
    if (text_ready_rx && frame_error) both_n <= both_n + 1;
    if (rx_busy) busy_n <= busy_n + 1;
  end

  typedef struct {
    logic [7:0] data;
    int         bit_cycles;
    logic       stop_bit;
    int         gap_after;
    logic       exp_strobe;
  } vec_t;

  vec_t       vecs [6];
  int         fall_cyc [6];
  logic [7:0] exp_q [$];
  int         tests = 0;
  int         fails = 0;
  int         rd = 0;
  int         base;
  int         d0;
  int         f0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge FPGA_clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input int bc, input logic stop_bit);
    serial_rx = 1'b0;
    idle(bc);
    for (int i = 0; i < 8; i++) begin
      serial_rx = data[i];
      idle(bc);
    end
    serial_rx = stop_bit;
    idle(bc);
    serial_rx = 1'b1;
  endtask

  task automatic drainStrobes(input int budget);
    int waited;
    waited = 0;
    while (rd < got_n || (exp_q.size() > 0 && waited < budget)) begin
      if (rd < got_n) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_strobe: got 0x%0h, expected no strobe", got_val[rd]);
        end else begin
          checkOutput("text_rx", int'(got_val[rd]), int'(exp_q.pop_front()));
        end
        rd++;
      end else begin
        idle(1);
        waited++;
      end
    end
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL missing_strobe: got none within %0d cycles, expected 0x%0h", budget, exp_q[0]);
      exp_q.delete();
    end
  endtask

  initial begin
    vecs[0] = '{ASCII_NEWLINE, CPB, 1'b1, 20, 1'b1};
    vecs[1] = '{8'h55, CPB, 1'b1, 0, 1'b1};
    vecs[2] = '{8'hA3, CPB, 1'b1, 0, 1'b1};
    vecs[3] = '{8'hFF, CPB, 1'b1, 20, 1'b1};
    vecs[4] = '{8'hC5, CPB - 1, 1'b1, 20, 1'b1};
    vecs[5] = '{8'hC5, CPB + 1, 1'b1, 20, 1'b1};

    reset = 1'b1;
    idle(3);
    checkOutput("reset_text_rx", int'(text_rx), 0);
    checkOutput("reset_ready", int'(text_ready_rx), 0);
    checkOutput("reset_frame_error", int'(frame_error), 0);
    checkOutput("reset_busy", int'(rx_busy), 0);
    reset = 1'b0;
    idle(5);

    base = got_n;
    for (int i = 0; i < 6; i++) begin
      fall_cyc[i] = cyc;
      if (vecs[i].exp_strobe) exp_q.push_back(vecs[i].data);
      applyStimulus(vecs[i].data, vecs[i].bit_cycles, vecs[i].stop_bit);
      idle(vecs[i].gap_after);
    end
    drainStrobes(400);
    checkOutput("latency_first", got_cyc[base] - fall_cyc[0], LATENCY);
    checkOutput("latency_b2b", got_cyc[base + 1] - fall_cyc[1], LATENCY);
    checkOutput("b2b_spacing_1", got_cyc[base + 2] - got_cyc[base + 1], 10 * CPB);
    checkOutput("b2b_spacing_2", got_cyc[base + 3] - got_cyc[base + 2], 10 * CPB);
    checkOutput("table_frame_errors", ferr_n, 0);

    // Short low glitch on an idle line.
    d0 = busy_n;
    serial_rx = 1'b0;
    idle(3);
    serial_rx = 1'b1;
    idle(30);
    checkOutput("glitch_busy_1_to_9", int'((busy_n - d0) >= 1 && (busy_n - d0) <= 9), 1);
    checkOutput("glitch_no_strobe", got_n - rd, 0);
    checkOutput("glitch_text_rx", int'(text_rx), 8'hC5);
    checkOutput("glitch_busy_after", int'(rx_busy), 0);

    // Bad stop bit followed by a held-low line.
    f0 = ferr_n;
    applyStimulus(8'h41, CPB, 1'b0);
    serial_rx = 1'b0;
    idle(50);
    checkOutput("break_no_strobe", got_n - rd, 0);
    checkOutput("break_text_rx", int'(text_rx), 8'hC5);
    checkOutput("break_busy", int'(rx_busy), 1);
    checkOutput("break_one_frame_error", ferr_n - f0, 1);
    serial_rx = 1'b1;
    idle(16);
    exp_q.push_back(8'h42);
    applyStimulus(8'h42, CPB, 1'b1);
    idle(20);
    drainStrobes(200);
    checkOutput("after_break_frame_errors", ferr_n - f0, 1);

    // Reset pulse in the middle of the data bits.
    serial_rx = 1'b0;
    idle(CPB);
    serial_rx = 1'b0;
    idle(CPB);
    serial_rx = 1'b1;
    idle(CPB);
    idle(CPB / 2);
    reset = 1'b1;
    serial_rx = 1'b1;
    idle(1);
    reset = 1'b0;
    checkOutput("midreset_text_rx", int'(text_rx), 0);
    checkOutput("midreset_ready", int'(text_ready_rx), 0);
    checkOutput("midreset_frame_error", int'(frame_error), 0);
    checkOutput("midreset_busy", int'(rx_busy), 0);
    idle(40);
    checkOutput("midreset_no_strobe", got_n - rd, 0);
    checkOutput("midreset_idle_busy", int'(rx_busy), 0);
    exp_q.push_back(8'h31);
    applyStimulus(8'h31, CPB, 1'b1);
    idle(20);
    drainStrobes(200);

    checkOutput("strobes_exclusive", both_n, 0);
    checkOutput("total_frame_errors", ferr_n, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion by %0t, expected summary", $time);
    $fatal(1);
  end

endmodule
